// File: rtl/div_unit_pkg.sv
// Shared constants for the multi-cycle divider.
//   div_state_e   : FSM state encoding (FREE/BY_ZERO/ON/END)
//   DIV_START/STOP, DIV_RESULT_READY/NOT_READY, SIGNED_DIV/UNSIGNED_DIV
package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic SIGNED_DIV           = 1'b1;
  localparam logic UNSIGNED_DIV         = 1'b0;

endpackage

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned divider for div/divu (radix-2 restoring,
// one quotient bit per clock). EX holds start_i high until it has consumed
// ready_o; the result is {remainder, quotient} for the HI/LO write.
// Ports:
//   clk, rst (async, active low)
//   start_i       request, held high until result consumed
//   annul_i       abort any divide (flush/exception), beats start_i
//   signed_div_i  1 = div, 0 = divu
//   opdata1_i     dividend, opdata2_i divisor (sampled on accept only)
//   result_o      {remainder, quotient}
//   ready_o       result valid, high throughout END
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

  div_state_e       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_divisor;
  logic             r_sign_a;
  logic             r_sign_b;
  logic             r_signed;

  logic [WIDTH-1:0] w_a_abs;
  logic [WIDTH-1:0] w_b_abs;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;

  // Magnitudes are taken only for signed divides. -0x80000000 wraps to
  // 0x80000000, which is the correct unsigned magnitude.
  assign w_a_abs = (signed_div_i == SIGNED_DIV && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign w_b_abs = (signed_div_i == SIGNED_DIV && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

  // Shift the next dividend bit into the partial remainder and try to
  // subtract; a borrow in the top bit means the divisor did not fit.
  assign w_trial = {r_rem, r_quo[WIDTH-1]} - {1'b0, r_divisor};

  // Quotient sign is the xor of operand signs; remainder follows dividend.
  assign w_quo_fix = (r_signed == SIGNED_DIV && (r_sign_a ^ r_sign_b)) ? -r_quo : r_quo;
  assign w_rem_fix = (r_signed == SIGNED_DIV && r_sign_a) ? -r_rem : r_rem;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= DIV_FREE;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_sign_a  <= 1'b0;
      r_sign_b  <= 1'b0;
      r_signed  <= 1'b0;
      result_o  <= '0;
      ready_o   <= DIV_RESULT_NOT_READY;
    end else if (annul_i) begin
      r_state  <= DIV_FREE;
      r_cnt    <= '0;
      result_o <= '0;
      ready_o  <= DIV_RESULT_NOT_READY;
    end else begin
      case (r_state)
        DIV_FREE: begin
          if (start_i == DIV_START) begin
            if (opdata2_i == '0) begin
              r_state <= DIV_BY_ZERO;
            end else begin
              r_state   <= DIV_ON;
              r_cnt     <= '0;
              r_rem     <= '0;
              r_quo     <= w_a_abs;
              r_divisor <= w_b_abs;
              r_sign_a  <= opdata1_i[WIDTH-1];
              r_sign_b  <= opdata2_i[WIDTH-1];
              r_signed  <= signed_div_i;
            end
          end
        end
        DIV_BY_ZERO: begin
          // Result is architecturally undefined; zero is returned, no trap.
          r_state  <= DIV_END;
          result_o <= '0;
          ready_o  <= DIV_RESULT_READY;
        end
        DIV_ON: begin
          if (r_cnt < CNT_LAST) begin
            r_cnt <= r_cnt + 1'b1;
            if (!w_trial[WIDTH]) begin
              r_rem <= w_trial[WIDTH-1:0];
              r_quo <= {r_quo[WIDTH-2:0], 1'b1};
            end else begin
              r_rem <= {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
              r_quo <= {r_quo[WIDTH-2:0], 1'b0};
            end
          end else begin
            r_state  <= DIV_END;
            r_cnt    <= '0;
            result_o <= {w_rem_fix, w_quo_fix};
            ready_o  <= DIV_RESULT_READY;
          end
        end
        DIV_END: begin
          // Hold the result until EX drops its request.
          if (start_i == DIV_STOP) begin
            r_state  <= DIV_FREE;
            result_o <= '0;
            ready_o  <= DIV_RESULT_NOT_READY;
          end
        end
        default: r_state <= DIV_FREE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic        signed_div_i = 1'b0;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic [63:0] result_o;
  logic        ready_o;

  int checks = 0;
  int errors = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  // Reference: plain wide arithmetic. SV division truncates toward zero and
  // the remainder takes the dividend's sign, matching MIPS div.
  function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint na, nb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      na = longint'($signed(a));
      nb = longint'($signed(b));
    end else begin
      na = longint'({32'd0, a});
      nb = longint'({32'd0, b});
    end
    q = na / nb;
    r = na % nb;
    return {r[31:0], q[31:0]};
  endfunction

  // Issue a request and wait for ready. lat = index of the first edge after
  // the accepting edge (E0 -> 0) where ready was seen, -1 on timeout.
  task automatic run_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] res, output int lat);
    @(negedge clk);
    signed_div_i = sgn; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready_o) begin lat = i; break; end
    end
    res = result_o;
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      errors++; $display("FAIL reset_asserted ready=%0b result=%h want 0/0", ready_o, result_o);
    end
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      errors++; $display("FAIL reset_released ready=%0b result=%h want 0/0", ready_o, result_o);
    end
  endtask

  task automatic test_divu_basic;
    logic [63:0] res; int lat;
    run_div(1'b0, 32'd100, 32'd7, res, lat);
    checks++;
    if (lat !== 33) begin errors++; $display("FAIL divu_latency got %0d want 33", lat); end
    checks++;
    if (res !== {32'd2, 32'd14}) begin errors++; $display("FAIL divu_100_7 got %h want %h", res, {32'd2, 32'd14}); end
    start_i = 1'b0;
    @(negedge clk);
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      errors++; $display("FAIL divu_release ready=%0b result=%h want 0/0", ready_o, result_o);
    end
  endtask

  task automatic test_signed;
    logic [63:0] res; int lat;
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, res, lat);
    checks++;
    if (res !== {32'hFFFF_FFFF, 32'hFFFF_FFFD} || lat !== 33) begin
      errors++; $display("FAIL div_m7_2 got %h lat %0d want %h lat 33", res, lat, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    end
    start_i = 1'b0; @(negedge clk);
    run_div(1'b1, 32'd7, 32'hFFFF_FFFE, res, lat);
    checks++;
    if (res !== {32'd1, 32'hFFFF_FFFD}) begin
      errors++; $display("FAIL div_7_m2 got %h want %h", res, {32'd1, 32'hFFFF_FFFD});
    end
    start_i = 1'b0; @(negedge clk);
  endtask

  task automatic test_div_zero;
    logic [63:0] res; int lat;
    run_div(1'b1, 32'd5, 32'd0, res, lat);
    checks++;
    if (lat < 0 || lat > 2) begin errors++; $display("FAIL divzero_latency got %0d want <=2", lat); end
    // Ready must still be up two edges after accept.
    if (lat == 1) @(negedge clk);
    checks++;
    if (ready_o !== 1'b1 || result_o !== 64'd0) begin
      errors++; $display("FAIL divzero_result ready=%0b result=%h want 1/0", ready_o, result_o);
    end
    start_i = 1'b0; @(negedge clk);
    checks++;
    if (ready_o !== 1'b0) begin errors++; $display("FAIL divzero_release ready=%0b want 0", ready_o); end
  endtask

  task automatic test_annul;
    logic [63:0] res; int lat; bit seen;
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd1234; opdata2_i = 32'd5; start_i = 1'b1;
    repeat (11) @(negedge clk);   // now after E10
    annul_i = 1'b1;               // start_i still high: annul must win
    @(negedge clk);
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      errors++; $display("FAIL annul_next ready=%0b result=%h want 0/0", ready_o, result_o);
    end
    @(negedge clk);               // annul+start together in FREE: no accept
    annul_i = 1'b0; start_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 36; i++) begin @(negedge clk); if (ready_o) seen = 1'b1; end
    checks++;
    if (seen) begin errors++; $display("FAIL annul_no_restart ready seen=1 want 0"); end
    run_div(1'b0, 32'hFFFF_FFFF, 32'd1, res, lat);
    checks++;
    if (res !== {32'd0, 32'hFFFF_FFFF} || lat !== 33) begin
      errors++; $display("FAIL annul_fresh got %h lat %0d want %h lat 33", res, lat, {32'd0, 32'hFFFF_FFFF});
    end
    start_i = 1'b0; @(negedge clk);
  endtask

  task automatic test_async_reset;
    logic [63:0] res; int lat;
    // Reset while in END: outputs clear before the next clock edge.
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, res, lat);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      errors++; $display("FAIL async_rst_end ready=%0b result=%h want 0/0", ready_o, result_o);
    end
    @(negedge clk); rst = 1'b1; start_i = 1'b0;
    // Reset mid-divide at step 20; nothing may resume afterwards.
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd999; opdata2_i = 32'd3; start_i = 1'b1;
    repeat (21) @(negedge clk);
    start_i = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      errors++; $display("FAIL async_rst_mid ready=%0b result=%h want 0/0", ready_o, result_o);
    end
    @(negedge clk); rst = 1'b1;
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, res, lat);
    checks++;
    if (res !== {32'd0, 32'h8000_0000} || lat !== 33) begin
      errors++; $display("FAIL div_min_m1 got %h lat %0d want %h lat 33", res, lat, {32'd0, 32'h8000_0000});
    end
    start_i = 1'b0; @(negedge clk);
  endtask

  task automatic test_operand_toggle;
    logic [31:0] a, b; logic [63:0] exp, held; int lat;
    a = $urandom; b = $urandom | 32'd1;
    exp = ref_div(1'b1, a, b);
    @(negedge clk);
    signed_div_i = 1'b1; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready_o) begin lat = i; break; end
      opdata1_i = $urandom; opdata2_i = $urandom; signed_div_i = ~signed_div_i;
      start_i = (i == 10) ? 1'b0 : 1'b1;  // re-pulse start mid-divide
    end
    held = result_o;
    checks++;
    if (held !== exp || lat !== 33) begin
      errors++; $display("FAIL toggle_result got %h lat %0d want %h lat 33", held, lat, exp);
    end
    for (int i = 0; i < 3; i++) begin
      opdata1_i = $urandom; opdata2_i = $urandom;
      @(negedge clk);
    end
    checks++;
    if (ready_o !== 1'b1 || result_o !== exp) begin
      errors++; $display("FAIL toggle_hold ready=%0b result=%h want 1/%h", ready_o, result_o, exp);
    end
    start_i = 1'b0; @(negedge clk);
  endtask

  task automatic test_random;
    logic [31:0] a, b; logic [63:0] res, exp; int lat; bit sgn;
    for (int n = 0; n < 24; n++) begin
      sgn = 1'($urandom_range(0, 1));
      a = (n % 7 == 3) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 20));
        2:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
        default: b = $urandom;
      endcase
      exp = ref_div(sgn, a, b);
      run_div(sgn, a, b, res, lat);
      checks++;
      if (res !== exp) begin
        errors++; $display("FAIL rand_result sgn=%0b a=%h b=%h got %h want %h", sgn, a, b, res, exp);
      end
      checks++;
      if ((b != 0 && lat !== 33) || (b == 0 && (lat < 0 || lat > 2))) begin
        errors++; $display("FAIL rand_latency b=%h got %0d want %0s", b, lat, (b == 0) ? "<=2" : "33");
      end
      start_i = 1'b0; @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_divu_basic();
    test_signed();
    test_div_zero();
    test_annul();
    test_async_reset();
    test_operand_toggle();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
